// File: rtl/mw_add_seq_pkg.sv
// Shared constants for the multi-word add/subtract sequencer.
// Word width is pinned to the fadd datapath; beat counter width derives from WORDS.
package mw_add_seq_pkg;

  localparam int ADD_W     = 32;
  localparam int DEF_WORDS = 4;

  // Beat counter needs at least one bit even for single-word operations.
  function automatic int beat_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mw_add_seq_fadd.sv
// 32-bit full adder with carry in/out; purely combinational, no flow control.
module fadd (
  input  logic        ci,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {32'd0, ci};

endmodule

// File: rtl/mw_add_seq.sv
// Multi-word add/sub sequencer: operands LSW-first, carry chained through fadd, 1-cycle result register.
// in_ready = !out_valid || out_ready, so a stalled result blocks input; full throughput when draining.
module mw_add_seq
  import mw_add_seq_pkg::*;
#(
  parameter int W     = ADD_W,
  parameter int WORDS = DEF_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_co,
  output logic         out_last,
  output logic         out_ovf
);

  localparam int BW = beat_w(WORDS);

  logic [BW-1:0] beat;
  logic          carry_q;
  logic          sub_q;

  logic          accept;
  logic          first;
  logic          is_last;
  logic          sub;
  logic          ci;
  logic [W-1:0]  b_eff;
  logic [W-1:0]  sum;
  logic          co;
  logic          ovf;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (beat == '0);
  assign is_last  = (beat == BW'(WORDS - 1));

  // Mode and carry come from the input only on beat 0; later beats use the latched chain state.
  assign sub   = first ? in_sub : sub_q;
  assign ci    = first ? (in_sub ? 1'b1 : in_cin) : carry_q;
  assign b_eff = sub ? ~in_b : in_b;

  fadd u_fadd (
    .ci  (ci),
    .a   (in_a),
    .b   (b_eff),
    .sum (sum),
    .co  (co)
  );

  assign ovf = is_last && (in_a[W-1] == b_eff[W-1]) && (sum[W-1] != in_a[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat    <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else if (accept) begin
      carry_q <= co;
      if (first) sub_q <= in_sub;
      beat <= is_last ? '0 : beat + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_co    <= 1'b0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sum;
      out_co    <= co;
      out_last  <= is_last;
      out_ovf   <= ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mw_add_seq.sv
// Directed bench for mw_add_seq with WORDS=4; operands packed with index 0 as the LSW.
module tb_mw_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_co;
  logic        out_last;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;
  int bp_t;

  logic [31:0] q_data[$];
  logic        q_co[$];
  logic        q_last[$];
  logic        q_ovf[$];

  always #5 clk = ~clk;

  mw_add_seq #(.W(32), .WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_co    (out_co),
    .out_last  (out_last),
    .out_ovf   (out_ovf)
  );

  // Records each result word that will be handshaken on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_co.push_back(out_co);
      q_last.push_back(out_last);
      q_ovf.push_back(out_ovf);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_co.delete();
    q_last.delete();
    q_ovf.delete();
  endtask

  task automatic send_words(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                            input logic cin, input logic sub, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = a[i];
      in_b     = b[i];
      in_cin   = cin;
      in_sub   = sub;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (q_data.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rx_count", 32'(q_data.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string tag, input logic [3:0][31:0] exp,
                          input logic co_last, input logic ovf_last);
    for (int i = 0; i < 4; i++) begin
      if (i < q_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), q_data[i], exp[i]);
        check($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == 3));
        if (i == 3) begin
          check($sformatf("%s_co", tag), 32'(q_co[i]), 32'(co_last));
          check($sformatf("%s_ovf", tag), 32'(q_ovf[i]), 32'(ovf_last));
        end else begin
          check($sformatf("%s_ovf%0d", tag, i), 32'(q_ovf[i]), 32'd0);
        end
      end
    end
    clear_q();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  out_data,       32'd0);
    @(posedge clk);
    #1;

    // Carry out of word 0 ripples into word 1.
    send_words({32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0, 1'b0, 4);
    wait_words(4);
    check_op("add1", {32'h0, 32'h0, 32'h1, 32'h0}, 1'b0, 1'b0);

    // Full-width wrap: carry out of the top word, no signed overflow.
    send_words({4{32'hFFFFFFFF}}, {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0, 1'b0, 4);
    wait_words(4);
    check_op("add2", {4{32'h0}}, 1'b1, 1'b0);

    // 3 - 5 = -2, borrow reported as out_co=0.
    send_words({32'h0, 32'h0, 32'h0, 32'h3}, {32'h0, 32'h0, 32'h0, 32'h5}, 1'b0, 1'b1, 4);
    wait_words(4);
    check_op("sub1", {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}, 1'b0, 1'b0);

    // Signed overflow in the top word, with output stalled for 3 cycles after word 2.
    fork
      send_words({32'h7FFFFFFF, 32'h0, 32'h0, 32'h0}, {32'h1, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 4);
      begin
        bp_t = 0;
        while (q_data.size() < 2 && bp_t < 100) begin
          @(posedge clk);
          #1;
          bp_t++;
        end
        check("bp_reach", 32'(q_data.size()), 32'd2);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready",  32'(in_ready),  32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
          check("bp_out_data",  out_data,       32'h0);
          check("bp_out_last",  32'(out_last),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_words(4);
    check_op("ovf", {32'h80000000, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1);

    // Reset after two words that leave the carry chain set; next op must start clean.
    send_words({4{32'hFFFFFFFF}}, {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0, 1'b0, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send_words({4{32'h0}}, {4{32'h0}}, 1'b0, 1'b0, 4);
    wait_words(4);
    check_op("post_rst", {4{32'h0}}, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
